// File: rtl/mips_cpu_pkg.sv
// Shared definitions for the MIPS CPU core: register indices and data types
// used by the register file and its read ports.
package mips_cpu_pkg;

  localparam int NUM_REGS  = 32;
  localparam int WORD_W    = 32;

  typedef logic [4:0]        reg_addr_t;
  typedef logic [WORD_W-1:0] word_t;

  localparam reg_addr_t REG_ZERO = 5'd0;
  localparam reg_addr_t REG_V0   = 5'd2;
  localparam reg_addr_t REG_RA   = 5'd31;

endpackage

// File: rtl/mips_cpu_reg_read_port.sv
// One combinational read port: forces index 0 to zero and, when
// MIPS_REG_FILE_BYPASS_EN is defined, forwards the in-flight write data.
module mips_cpu_reg_read_port
  import mips_cpu_pkg::*;
(
  input  logic [4:0]  i_addr,
  input  logic [31:0] i_stored,
  input  logic        i_wr_en,
  input  logic [4:0]  i_wr_addr,
  input  logic [31:0] i_wr_data,
  output logic [31:0] o_data
);

`ifndef MIPS_REG_FILE_BYPASS_EN
  logic w_unused_bypass;
  assign w_unused_bypass = ^{i_wr_en, i_wr_addr, i_wr_data};
`endif

  always_comb begin
    o_data = i_stored;
`ifdef MIPS_REG_FILE_BYPASS_EN
    if (i_wr_en && (i_wr_addr == i_addr)) o_data = i_wr_data;
`endif
    // Zero forcing last so a bypass to index 0 can never leak through.
    if (i_addr == REG_ZERO) o_data = '0;
  end

endmodule

// File: rtl/mips_cpu_reg_file.sv
// 32 x 32-bit MIPS register file: two combinational read ports, one write
// port, dedicated $v0 output. Optional forwarding: MIPS_REG_FILE_BYPASS_EN.
module mips_cpu_reg_file
  import mips_cpu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  read_addr1,
  input  logic [4:0]  read_addr2,
  input  logic [4:0]  write_addr,
  input  logic [31:0] write_data,
  input  logic        write_enable,
  output logic [31:0] read_data1,
  output logic [31:0] read_data2,
  output logic [31:0] register_v0
);

  // No handshakes: reads are valid every cycle, writes commit on any enabled edge.
  word_t r_regs [NUM_REGS];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
    end else if (write_enable && (write_addr != REG_ZERO)) begin
      r_regs[write_addr] <= write_data;
    end
  end

  word_t w_stored1;
  word_t w_stored2;
  assign w_stored1 = r_regs[read_addr1];
  assign w_stored2 = r_regs[read_addr2];

  mips_cpu_reg_read_port u_port1 (
    .i_addr    (read_addr1),
    .i_stored  (w_stored1),
    .i_wr_en   (write_enable),
    .i_wr_addr (write_addr),
    .i_wr_data (write_data),
    .o_data    (read_data1)
  );

  mips_cpu_reg_read_port u_port2 (
    .i_addr    (read_addr2),
    .i_stored  (w_stored2),
    .i_wr_en   (write_enable),
    .i_wr_addr (write_addr),
    .i_wr_data (write_data),
    .o_data    (read_data2)
  );

`ifdef MIPS_REG_FILE_BYPASS_EN
  assign register_v0 = (write_enable && (write_addr == REG_V0)) ? write_data
                                                                : r_regs[REG_V0];
`else
  assign register_v0 = r_regs[REG_V0];
`endif

endmodule

// File: tb/tb_mips_cpu_reg_file.sv
// Self-checking bench for mips_cpu_reg_file: directed steps followed by a
// randomized phase against an array-based reference model.
module tb_mips_cpu_reg_file;

`ifdef MIPS_REG_FILE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic [4:0]  read_addr1;
  logic [4:0]  read_addr2;
  logic [4:0]  write_addr;
  logic [31:0] write_data;
  logic        write_enable;
  logic [31:0] read_data1;
  logic [31:0] read_data2;
  logic [31:0] register_v0;

  int checks = 0;
  int errors = 0;

  logic [31:0] model [32];

  mips_cpu_reg_file dut (
    .clk          (clk),
    .reset        (reset),
    .read_addr1   (read_addr1),
    .read_addr2   (read_addr2),
    .write_addr   (write_addr),
    .write_data   (write_data),
    .write_enable (write_enable),
    .read_data1   (read_data1),
    .read_data2   (read_data2),
    .register_v0  (register_v0)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout observed=running required=finished");
    $fatal(1, "timeout");
  end

  // Reference: what a read of addr must return given current inputs.
  function automatic logic [31:0] exp_read(input logic [4:0] addr);
    if (!reset || addr == 5'd0) return 32'h0;
    if (BYPASS && write_enable && write_addr == addr) return write_data;
    return model[addr];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, "_rd1"}, read_data1, exp_read(read_addr1));
    check({tag, "_rd2"}, read_data2, exp_read(read_addr2));
    check({tag, "_v0"}, register_v0, exp_read(5'd2));
  endtask

  task automatic clear_model();
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
  endtask

  // Driver: called at a negedge, returns at the next negedge.
  task automatic step(input string tag, input logic [4:0] wa, input logic [31:0] wd,
                      input logic we, input logic [4:0] ra1, input logic [4:0] ra2);
    write_addr   = wa;
    write_data   = wd;
    write_enable = we;
    read_addr1   = ra1;
    read_addr2   = ra2;
    #1;
    check_all({tag, "_pre"});
    @(posedge clk);
    if (we && reset && wa != 5'd0) model[wa] = wd;
    #1;
    check_all({tag, "_post"});
    @(negedge clk);
    write_enable = 1'b0;
  endtask

  initial begin
    clear_model();
    reset = 1'b0;
    write_enable = 1'b0;
    write_addr = 5'd0;
    write_data = 32'h0;
    read_addr1 = 5'd5;
    read_addr2 = 5'd2;
    #2;
    check_all("reset_init");
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // Basic write/read, both ports on the same index
    step("wr5", 5'd5, 32'hDEADBEEF, 1'b1, 5'd5, 5'd5);
    check("wr5_value", read_data1, 32'hDEADBEEF);
    // Zero register
    step("wr0", 5'd0, 32'hFFFFFFFF, 1'b1, 5'd0, 5'd0);
    check("zero_rd1", read_data1, 32'h0);
    check("zero_rd2", read_data2, 32'h0);
    // Enable gating
    step("nowe7", 5'd7, 32'h12345678, 1'b0, 5'd7, 5'd5);
    check("nowe7_value", read_data1, 32'h0);
    // $v0 tracking
    step("v0", 5'd2, 32'h00000042, 1'b1, 5'd2, 5'd3);
    check("v0_value", register_v0, 32'h42);
    step("wr3", 5'd3, 32'h00000099, 1'b1, 5'd3, 5'd2);
    check("v0_hold", register_v0, 32'h42);
    // Same-cycle read of the address being written
    step("wr9a", 5'd9, 32'h1, 1'b1, 5'd9, 5'd9);
    write_addr = 5'd9; write_data = 32'h2; write_enable = 1'b1;
    read_addr1 = 5'd9; read_addr2 = 5'd9;
    #1;
    check("bypass9_pre", read_data1, BYPASS ? 32'h2 : 32'h1);
    @(posedge clk);
    model[9] = 32'h2;
    #1;
    check("bypass9_post", read_data2, 32'h2);
    @(negedge clk);
    write_enable = 1'b0;
    step("wr31", 5'd31, 32'hA5A5A5A5, 1'b1, 5'd31, 5'd9);

    // Randomized phase, biased toward address collisions
    for (int n = 0; n < 300; n++) begin
      logic [4:0] wa, ra1, ra2;
      wa  = 5'($urandom_range(0, 31));
      ra1 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
      ra2 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
      step("rand", wa, $urandom, 1'($urandom_range(0, 1)), ra1, ra2);
    end

    // Asynchronous reset mid-run: outputs clear without a clock edge
    model[2] = model[2];
    step("pre_rst", 5'd2, 32'hCAFEF00D, 1'b1, 5'd2, 5'd31);
    read_addr1 = 5'd2;
    read_addr2 = 5'd31;
    #1;
    reset = 1'b0;
    clear_model();
    #1;
    check("async_rd1", read_data1, 32'h0);
    check("async_rd2", read_data2, 32'h0);
    check("async_v0", register_v0, 32'h0);
    // Reset dominates an enabled write on the same edge
    write_addr = 5'd4; write_data = 32'h77777777; write_enable = 1'b1;
    read_addr1 = 5'd4;
    @(posedge clk);
    #1;
    check("rst_dom_rd1", read_data1, 32'h0);
    @(negedge clk);
    write_enable = 1'b0;
    reset = 1'b1;
    #1;
    for (int i = 0; i < 32; i++) begin
      read_addr1 = 5'(i);
      read_addr2 = 5'(31 - i);
      #1;
      check("post_rst_rd1", read_data1, 32'h0);
      check("post_rst_rd2", read_data2, 32'h0);
    end
    @(negedge clk);
    step("after_rst", 5'd4, 32'h01020304, 1'b1, 5'd4, 5'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
